// File: rtl/alu_md.sv
`default_nettype none
// ============================================================================
// Module  : alu_md
// Purpose : Base ALU (single cycle) plus iterative RV32M-style multiply/divide
// Rev     : 1.0
// ============================================================================
module alu_md #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             kill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             busy
);
    localparam int              CW      = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]   LAST    = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [2:0]             f3_q;
    logic [2*WIDTH-1:0]     prod_q;
    logic [WIDTH-1:0]       bm_q;
    logic [WIDTH:0]         rem_q;
    logic [WIDTH-1:0]       quo_q;
    logic                   neg_q;
    logic                   rneg_q;
    logic [WIDTH-1:0]       result_q;
    logic                   zero_q;
    logic                   ovf_q;

    logic                   accept;
    logic [2:0]             f3;
    logic [WIDTH-1:0]       add_s, sub_s, base_res, fast_res, fix_res;
    logic                   base_ovf;
    logic                   a_sgn, b_sgn, a_neg, b_neg, div_by0, div_ovf;
    logic [WIDTH-1:0]       a_mag, b_mag;
    logic [WIDTH:0]         mul_sum;
    logic [2*WIDTH-1:0]     prod_d, prod_fix;
    logic [WIDTH:0]         div_sh, rem_d;
    logic [WIDTH+1:0]       div_diff;
    logic [WIDTH-1:0]       quo_d, quo_fix, rem_fix;

    assign in_ready  = ((state_q == S_IDLE) || (state_q == S_DONE && out_ready)) && !kill;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
    assign result    = result_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;

    assign f3    = op[2:0];
    assign add_s = a + b;
    assign sub_s = a - b;

    always_comb begin
        base_res = '0;
        base_ovf = 1'b0;
        case (op[3:0])
            4'b0000: base_res = a & b;
            4'b0001: base_res = a | b;
            4'b0010: begin
                base_res = add_s;
                base_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0110: begin
                base_res = sub_s;
                base_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_s[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0111: base_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            4'b1100: base_res = ~(a | b);
            default: base_res = '0;
        endcase
    end

    // Signedness per operand: DIV/REM both signed; MULH both; MULHSU only a.
    assign a_sgn    = f3[2] ? ~f3[0] : ((f3 == 3'b001) || (f3 == 3'b010));
    assign b_sgn    = f3[2] ? ~f3[0] : (f3 == 3'b001);
    assign a_neg    = a_sgn & a[WIDTH-1];
    assign b_neg    = b_sgn & b[WIDTH-1];
    assign a_mag    = a_neg ? -a : a;
    assign b_mag    = b_neg ? -b : b;
    assign div_by0  = (b == '0);
    assign div_ovf  = ~f3[0] && (a == MIN_NEG) && (&b);
    assign fast_res = div_by0 ? (f3[1] ? a : '1) : (f3[1] ? '0 : a);

    assign mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, bm_q} : '0);
    assign prod_d  = {mul_sum, prod_q[WIDTH-1:1]};

    // rem_q[WIDTH] stays 0 in a restoring divider; folding it in keeps the sign test exact.
    assign div_sh   = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign div_diff = {rem_q[WIDTH], div_sh} - {2'b00, bm_q};
    assign rem_d    = div_diff[WIDTH+1] ? div_sh : div_diff[WIDTH:0];
    assign quo_d    = {quo_q[WIDTH-2:0], ~div_diff[WIDTH+1]};

    assign prod_fix = neg_q  ? -prod_q : prod_q;
    assign quo_fix  = neg_q  ? -quo_q  : quo_q;
    assign rem_fix  = rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    assign fix_res  = f3_q[2] ? (f3_q[1] ? rem_fix : quo_fix)
                              : ((f3_q == 3'b000) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            prod_q   <= '0;
            bm_q     <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (kill) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        if (!op[4]) begin
                            result_q <= base_res;
                            zero_q   <= (base_res == '0);
                            ovf_q    <= base_ovf;
                            state_q  <= S_DONE;
                        end else if (f3[2] && (div_by0 || div_ovf)) begin
                            result_q <= fast_res;
                            zero_q   <= (fast_res == '0);
                            ovf_q    <= 1'b0;
                            state_q  <= S_DONE;
                        end else begin
                            f3_q   <= f3;
                            cnt_q  <= '0;
                            bm_q   <= b_mag;
                            neg_q  <= a_neg ^ b_neg;
                            rneg_q <= a_neg;
                            if (f3[2]) begin
                                rem_q   <= '0;
                                quo_q   <= a_mag;
                                state_q <= S_DIV;
                            end else begin
                                prod_q  <= {{WIDTH{1'b0}}, a_mag};
                                state_q <= S_MUL;
                            end
                        end
                    end else if (state_q == S_DONE && out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                S_MUL: begin
                    prod_q <= prod_d;
                    cnt_q  <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
                    if (cnt_q == LAST) state_q <= S_FIX;
                end
                S_DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
                    if (cnt_q == LAST) state_q <= S_FIX;
                end
                S_FIX: begin
                    result_q <= fix_res;
                    zero_q   <= (fix_res == '0);
                    ovf_q    <= 1'b0;
                    state_q  <= S_DONE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: doc/alu_md.md
ALU_MD -- requirements
Module: alu_md

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; legal values 8..64, even.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  request accepted on cycle where in_valid & in_ready.
REQ-006 op  input  5  op[4]=0: base op, op[3:0]={Ainvert,Bnegate,Op[1:0]}; op[4]=1: op[2:0]=M-ext funct3.
REQ-007 a, b  input  WIDTH each  operands.
REQ-008 kill  input  1  synchronous abort of in-flight operation.
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  consumer takes result when out_valid & out_ready.
REQ-011 result  output  WIDTH  registered result.
REQ-012 zero  output  1  registered, 1 iff result==0.
REQ-013 overflow  output  1  registered signed overflow; ADD/SUB only, else 0.
REQ-014 busy  output  1  high in states MUL, DIV, FIX.

Function
REQ-015 Base ops: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 0/1), 1100 NOR; other base codes produce result 0, overflow 0.
REQ-016 M ops (funct3): 000 MUL (low), 001 MULH (s*s high), 010 MULHSU (s*u high), 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU; RISC-V semantics, truncating division, remainder sign follows dividend.
REQ-017 States: IDLE, MUL, DIV, FIX, DONE; reset state IDLE.
REQ-018 in_ready = (state==IDLE) | (state==DONE & out_ready) and not kill.
REQ-019 Accept in IDLE/DONE: base op -> result computed, registered, state DONE; out_valid high the next cycle (latency 1).
REQ-020 Accept of MUL* -> state MUL: operands converted to magnitudes, one shift-add step per cycle, exactly WIDTH cycles, then FIX.
REQ-021 Accept of DIV*/REM* with b!=0 and not signed overflow -> state DIV: one restoring step per cycle, exactly WIDTH cycles, then FIX.
REQ-022 FIX: one cycle applying sign correction and high/low select, then DONE; M-op latency accept-to-out_valid = WIDTH+2 cycles.
REQ-023 Divide by zero takes fast path (latency 1): DIV/DIVU result all-ones, REM/REMU result = a.
REQ-024 Signed overflow (a = most-negative, b = -1) fast path: DIV result = a, REM result 0.
REQ-025 DONE: result/zero/overflow held stable while out_valid & !out_ready.
REQ-026 DONE with out_ready & in_valid: new request accepted same cycle, back-to-back, no bubble for base ops.
REQ-027 DONE with out_ready & !in_valid: next state IDLE, out_valid 0.
REQ-028 kill in any state: next state IDLE, out_valid 0, no accept that cycle, result register unchanged; kill in IDLE is a no-op.
REQ-029 Internal accumulators WIDTH*2 bits for multiply, WIDTH+1 bits for divide remainder; no truncation before FIX.
REQ-030 zero and overflow update only when result updates.

Reset
REQ-031 rst_n low: immediately state IDLE, out_valid 0, result 0, zero 0, overflow 0, busy 0, all iteration counters 0; in_ready 1 after deassertion.
REQ-032 Reset asserted mid MUL/DIV discards operation; no out_valid after release.

Verification (WIDTH=32)
REQ-033 Reset: rst_n low mid-DIV -> out_valid=0, result=0, busy=0, in_ready=1 after release.
REQ-034 ADD a=0x7FFFFFFF b=1 -> next cycle out_valid=1, result=0x80000000, overflow=1; SUB 5-5 -> result 0, zero=1; SLT 0xFFFFFFFF,1 -> result 1.
REQ-035 MULHU a=b=0xFFFFFFFF -> out_valid exactly 34 cycles after accept, result=0xFFFFFFFE; MUL same operands -> result 1.
REQ-036 DIV a=0xFFFFFFF9 (-7) b=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU a=5 b=0 -> 0xFFFFFFFF after 1 cycle; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, overflow=0.
REQ-037 Backpressure: out_ready low 3 cycles -> result and out_valid stable; then out_ready & in_valid (AND) same cycle -> next result next cycle, no bubble.
REQ-038 kill 10 cycles into MUL -> next cycle IDLE, busy=0, out_valid never asserts for that op, following ADD completes normally.
